// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register" ID
// and the forward-source selector used by the decode stage.
package y86_pkg;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   localparam logic [2:0] S_AOK = 3'd1;
   localparam logic [2:0] S_HLT = 3'd2;
   localparam logic [2:0] S_ADR = 3'd3;
   localparam logic [2:0] S_INS = 3'd4;

   localparam logic [3:0] RNONE = 4'hF;

   // Where a decoded operand value comes from; order of the forward chain.
   typedef enum logic [2:0] {
      FWD_RF,
      FWD_VALP,
      FWD_E,
      FWD_MM,
      FWD_ME,
      FWD_WM,
      FWD_WE
   } fwd_sel_e;

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: NREGS x DATA_W, two async read ports, two sync write ports
// (port M wins over port E on the same ID). Out-of-range and RNONE IDs read 0 / write nothing.
module y86_regfile #(
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       REG_AW    = 4,
   parameter int unsigned       NREGS     = 15,
   parameter int unsigned       RSP_IDX   = 4,
   parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] src_a,
   input  logic [REG_AW-1:0] src_b,
   output logic [DATA_W-1:0] rd_a,
   output logic [DATA_W-1:0] rd_b,
   input  logic [REG_AW-1:0] dst_e,
   input  logic [DATA_W-1:0] val_e,
   input  logic [REG_AW-1:0] dst_m,
   input  logic [DATA_W-1:0] val_m
);

   localparam logic [REG_AW-1:0] LAST_ID = REG_AW'(NREGS - 1);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   always_comb begin
      for (int unsigned i = 0; i < NREGS; i++) begin
         regs_d[i] = regs_q[i];
         if (dst_e == REG_AW'(i)) regs_d[i] = val_e;
         if (dst_m == REG_AW'(i)) regs_d[i] = val_m;
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
         if (rst) regs_q[i] <= (i == RSP_IDX) ? RSP_RESET : '0;
         else     regs_q[i] <= regs_d[i];
      end
   end

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      if (src_a <= LAST_ID) rd_a = regs_q[src_a];
      if (src_b <= LAST_ID) rd_b = regs_q[src_b];
   end

endmodule

// File: rtl/decode_fwd_stage.sv
// Y86-64 decode stage: field decode, register file, e/M/W forwarding, load-use detect
// and the E pipeline register. Optional counters enabled by DECODE_PERF_CNT_EN.
module decode_fwd_stage
   import y86_pkg::*;
#(
   parameter int unsigned       DATA_W    = 64,
   parameter int unsigned       REG_AW    = 4,
   parameter int unsigned       NREGS     = 15,
   parameter int unsigned       RSP_IDX   = 4,
   parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        D_stat,
   input  logic [3:0]        D_icode,
   input  logic [3:0]        D_ifun,
   input  logic [REG_AW-1:0] D_rA,
   input  logic [REG_AW-1:0] D_rB,
   input  logic [DATA_W-1:0] D_valC,
   input  logic [DATA_W-1:0] D_valP,
   input  logic [REG_AW-1:0] e_dstE,
   input  logic [DATA_W-1:0] e_valE,
   input  logic [REG_AW-1:0] M_dstM,
   input  logic [DATA_W-1:0] m_valM,
   input  logic [REG_AW-1:0] M_dstE,
   input  logic [DATA_W-1:0] M_valE,
   input  logic [REG_AW-1:0] W_dstM,
   input  logic [DATA_W-1:0] W_valM,
   input  logic [REG_AW-1:0] W_dstE,
   input  logic [DATA_W-1:0] W_valE,
   input  logic              E_stall,
   input  logic              E_bubble,
   output logic [REG_AW-1:0] d_srcA,
   output logic [REG_AW-1:0] d_srcB,
   output logic              d_load_use,
   output logic [2:0]        E_stat,
   output logic [3:0]        E_icode,
   output logic [3:0]        E_ifun,
   output logic [DATA_W-1:0] E_valA,
   output logic [DATA_W-1:0] E_valB,
   output logic [DATA_W-1:0] E_valC,
   output logic [REG_AW-1:0] E_dstE,
   output logic [REG_AW-1:0] E_dstM,
   output logic [REG_AW-1:0] E_srcA,
   output logic [REG_AW-1:0] E_srcB
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fwd_cnt,
   output logic [31:0]       perf_bubble_cnt
`endif
);

   localparam logic [REG_AW-1:0] R_NONE = '1;
   localparam logic [REG_AW-1:0] RSP_ID = REG_AW'(RSP_IDX);

   logic [REG_AW-1:0] dec_dst_e, dec_dst_m;
   logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
   fwd_sel_e          sel_a, sel_b;

   always_comb begin
      d_srcA    = R_NONE;
      d_srcB    = R_NONE;
      dec_dst_e = R_NONE;
      dec_dst_m = R_NONE;
      case (D_icode)
         I_RRMOVQ: begin d_srcA = D_rA; dec_dst_e = D_rB; end
         I_IRMOVQ: dec_dst_e = D_rB;
         I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
         I_MRMOVQ: begin d_srcB = D_rB; dec_dst_m = D_rA; end
         I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; dec_dst_e = D_rB; end
         I_CALL:   begin d_srcB = RSP_ID; dec_dst_e = RSP_ID; end
         I_RET:    begin d_srcA = RSP_ID; d_srcB = RSP_ID; dec_dst_e = RSP_ID; end
         I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP_ID; dec_dst_e = RSP_ID; end
         I_POPQ:   begin
            d_srcA = RSP_ID; d_srcB = RSP_ID; dec_dst_e = RSP_ID; dec_dst_m = D_rA;
         end
         default: ;
      endcase
   end

   y86_regfile #(
      .DATA_W    (DATA_W),
      .REG_AW    (REG_AW),
      .NREGS     (NREGS),
      .RSP_IDX   (RSP_IDX),
      .RSP_RESET (RSP_RESET)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .src_a (d_srcA),
      .src_b (d_srcB),
      .rd_a  (rf_a),
      .rd_b  (rf_b),
      .dst_e (W_dstE),
      .val_e (W_valE),
      .dst_m (W_dstM),
      .val_m (W_valM)
   );

   // Forward chain, youngest producer first; an RNONE source never matches.
   always_comb begin
      sel_a = FWD_RF;
      if (D_icode == I_JXX || D_icode == I_CALL) sel_a = FWD_VALP;
      else if (d_srcA != R_NONE) begin
         if      (d_srcA == e_dstE) sel_a = FWD_E;
         else if (d_srcA == M_dstM) sel_a = FWD_MM;
         else if (d_srcA == M_dstE) sel_a = FWD_ME;
         else if (d_srcA == W_dstM) sel_a = FWD_WM;
         else if (d_srcA == W_dstE) sel_a = FWD_WE;
      end
      sel_b = FWD_RF;
      if (d_srcB != R_NONE) begin
         if      (d_srcB == e_dstE) sel_b = FWD_E;
         else if (d_srcB == M_dstM) sel_b = FWD_MM;
         else if (d_srcB == M_dstE) sel_b = FWD_ME;
         else if (d_srcB == W_dstM) sel_b = FWD_WM;
         else if (d_srcB == W_dstE) sel_b = FWD_WE;
      end
   end

   always_comb begin
      case (sel_a)
         FWD_VALP: val_a = D_valP;
         FWD_E:    val_a = e_valE;
         FWD_MM:   val_a = m_valM;
         FWD_ME:   val_a = M_valE;
         FWD_WM:   val_a = W_valM;
         FWD_WE:   val_a = W_valE;
         default:  val_a = rf_a;
      endcase
      case (sel_b)
         FWD_E:    val_b = e_valE;
         FWD_MM:   val_b = m_valM;
         FWD_ME:   val_b = M_valE;
         FWD_WM:   val_b = W_valM;
         FWD_WE:   val_b = W_valE;
         default:  val_b = rf_b;
      endcase
   end

   logic [2:0]        ereg_stat_q,  ereg_stat_d;
   logic [3:0]        ereg_icode_q, ereg_icode_d;
   logic [3:0]        ereg_ifun_q,  ereg_ifun_d;
   logic [DATA_W-1:0] ereg_vala_q,  ereg_vala_d;
   logic [DATA_W-1:0] ereg_valb_q,  ereg_valb_d;
   logic [DATA_W-1:0] ereg_valc_q,  ereg_valc_d;
   logic [REG_AW-1:0] ereg_dste_q,  ereg_dste_d;
   logic [REG_AW-1:0] ereg_dstm_q,  ereg_dstm_d;
   logic [REG_AW-1:0] ereg_srca_q,  ereg_srca_d;
   logic [REG_AW-1:0] ereg_srcb_q,  ereg_srcb_d;

   always_comb begin
      d_load_use = (ereg_icode_q == I_MRMOVQ || ereg_icode_q == I_POPQ) &&
                   (ereg_dstm_q != R_NONE) &&
                   (ereg_dstm_q == d_srcA || ereg_dstm_q == d_srcB);
   end

   always_comb begin
      ereg_stat_d  = ereg_stat_q;
      ereg_icode_d = ereg_icode_q;
      ereg_ifun_d  = ereg_ifun_q;
      ereg_vala_d  = ereg_vala_q;
      ereg_valb_d  = ereg_valb_q;
      ereg_valc_d  = ereg_valc_q;
      ereg_dste_d  = ereg_dste_q;
      ereg_dstm_d  = ereg_dstm_q;
      ereg_srca_d  = ereg_srca_q;
      ereg_srcb_d  = ereg_srcb_q;
      if (E_bubble) begin
         ereg_stat_d  = S_AOK;
         ereg_icode_d = I_NOP;
         ereg_ifun_d  = '0;
         ereg_vala_d  = '0;
         ereg_valb_d  = '0;
         ereg_valc_d  = '0;
         ereg_dste_d  = R_NONE;
         ereg_dstm_d  = R_NONE;
         ereg_srca_d  = R_NONE;
         ereg_srcb_d  = R_NONE;
      end else if (!E_stall) begin
         ereg_stat_d  = D_stat;
         ereg_icode_d = D_icode;
         ereg_ifun_d  = D_ifun;
         ereg_vala_d  = val_a;
         ereg_valb_d  = val_b;
         ereg_valc_d  = D_valC;
         ereg_dste_d  = dec_dst_e;
         ereg_dstm_d  = dec_dst_m;
         ereg_srca_d  = d_srcA;
         ereg_srcb_d  = d_srcB;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ereg_stat_q  <= S_AOK;
         ereg_icode_q <= I_NOP;
         ereg_ifun_q  <= '0;
         ereg_vala_q  <= '0;
         ereg_valb_q  <= '0;
         ereg_valc_q  <= '0;
         ereg_dste_q  <= R_NONE;
         ereg_dstm_q  <= R_NONE;
         ereg_srca_q  <= R_NONE;
         ereg_srcb_q  <= R_NONE;
      end else begin
         ereg_stat_q  <= ereg_stat_d;
         ereg_icode_q <= ereg_icode_d;
         ereg_ifun_q  <= ereg_ifun_d;
         ereg_vala_q  <= ereg_vala_d;
         ereg_valb_q  <= ereg_valb_d;
         ereg_valc_q  <= ereg_valc_d;
         ereg_dste_q  <= ereg_dste_d;
         ereg_dstm_q  <= ereg_dstm_d;
         ereg_srca_q  <= ereg_srca_d;
         ereg_srcb_q  <= ereg_srcb_d;
      end
   end

   assign E_stat  = ereg_stat_q;
   assign E_icode = ereg_icode_q;
   assign E_ifun  = ereg_ifun_q;
   assign E_valA  = ereg_vala_q;
   assign E_valB  = ereg_valb_q;
   assign E_valC  = ereg_valc_q;
   assign E_dstE  = ereg_dste_q;
   assign E_dstM  = ereg_dstm_q;
   assign E_srcA  = ereg_srca_q;
   assign E_srcB  = ereg_srcb_q;

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_fwd_cnt_q,    perf_fwd_cnt_d;
   logic [31:0] perf_bubble_cnt_q, perf_bubble_cnt_d;

   // valP selection is not a forward, so only the register forward sources count.
   always_comb begin
      perf_fwd_cnt_d    = perf_fwd_cnt_q;
      perf_bubble_cnt_d = perf_bubble_cnt_q;
      if (E_bubble) perf_bubble_cnt_d = perf_bubble_cnt_q + 32'd1;
      else if (!E_stall &&
               ((sel_a != FWD_RF && sel_a != FWD_VALP) || sel_b != FWD_RF))
         perf_fwd_cnt_d = perf_fwd_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fwd_cnt_q    <= '0;
         perf_bubble_cnt_q <= '0;
      end else begin
         perf_fwd_cnt_q    <= perf_fwd_cnt_d;
         perf_bubble_cnt_q <= perf_bubble_cnt_d;
      end
   end

   assign perf_fwd_cnt    = perf_fwd_cnt_q;
   assign perf_bubble_cnt = perf_bubble_cnt_q;
`endif

endmodule
